// File: rtl/div_unit.sv
// Multi-cycle signed integer divider: restoring division on operand magnitudes, one step per
// clock, with the result signs applied on a registered one-cycle ready strobe.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    state_t          start_state_s;
    logic [CW-1:0]   count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_mag_r;
    logic            sign_a_r;
    logic            sign_b_r;
    logic            dz_r;

    logic            div_zero_s;
    logic [WIDTH:0]  shift_s;
    logic [WIDTH:0]  trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic            rdy_s;
    logic [WIDTH-1:0] quo_res_s;
    logic [WIDTH-1:0] rem_res_s;
    logic            exc_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Unsigned magnitude; the most negative value maps exactly onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    assign div_zero_s    = (divisor == ZERO_W);
    assign start_state_s = div_zero_s ? DONE : RUN;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a start strobe restarts from any state.
    always_comb begin
        state_s = state_r;
        if (ctrl_DIV) begin
            state_s = start_state_s;
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                RUN:     state_s = (count_r == CNT_LAST) ? DONE : RUN;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // One restoring step: shift {R,Q}, trial-subtract at WIDTH+1 bits, keep R if negative.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, div_mag_r};
        if (!trial_s[WIDTH]) begin
            rem_next_s = trial_s[WIDTH-1:0];
        end else begin
            rem_next_s = shift_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
    end

    // Work registers: operand capture on start, one division step per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= CNT_ZERO;
            rem_r     <= ZERO_W;
            quo_r     <= ZERO_W;
            div_mag_r <= ZERO_W;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            dz_r      <= 1'b0;
        end else if (ctrl_DIV) begin
            count_r <= CNT_ZERO;
            rem_r   <= ZERO_W;
            if (div_zero_s) begin
                quo_r     <= ZERO_W;
                div_mag_r <= ZERO_W;
                sign_a_r  <= 1'b0;
                sign_b_r  <= 1'b0;
                dz_r      <= 1'b1;
            end else begin
                quo_r     <= magnitude(dividend);
                div_mag_r <= magnitude(divisor);
                sign_a_r  <= dividend[WIDTH-1];
                sign_b_r  <= divisor[WIDTH-1];
                dz_r      <= 1'b0;
            end
        end else if (state_r == RUN) begin
            count_r <= count_r + CNT_ONE;
            rem_r   <= rem_next_s;
            quo_r   <= quo_next_s;
        end
    end

    // Output decode: signed results are formed from the magnitudes while in DONE.
    always_comb begin
        rdy_s     = (state_r == DONE);
        exc_s     = dz_r;
        quo_res_s = (sign_a_r ^ sign_b_r) ? negate(quo_r) : quo_r;
        rem_res_s = sign_a_r ? negate(rem_r) : rem_r;
    end

    // Output registers: results load on the DONE cycle and hold until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quotient       <= ZERO_W;
            remainder      <= ZERO_W;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= rdy_s;
            busy           <= (state_s != IDLE);
            if (rdy_s) begin
                quotient       <= quo_res_s;
                remainder      <= rem_res_s;
                data_exception <= exc_s;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and small randomized bench for div_unit: latency, sign handling, divide-by-zero,
// restart/abort behaviour and asynchronous reset.
module tb_div_unit;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int err_cnt;
    int chk_cnt;

    div_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .dividend       (dividend),
        .divisor        (divisor),
        .quotient       (quotient),
        .remainder      (remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the falling edge just after the sampling edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    // Watches a fixed window after a start and checks strobe count, latency, results and hold.
    task automatic wait_result(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_exc, input int exp_lat);
        int          n_strb;
        int          lat;
        logic [31:0] q_c;
        logic [31:0] r_c;
        logic        e_c;
        n_strb = 0;
        lat    = 0;
        q_c    = 32'h0;
        r_c    = 32'h0;
        e_c    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 1 && exp_lat > 1) check_val({tag, " busy"}, {31'h0, busy}, 32'h1);
            if (data_resultRDY) begin
                n_strb++;
                if (n_strb == 1) begin
                    lat = c;
                    q_c = quotient;
                    r_c = remainder;
                    e_c = data_exception;
                end
            end
        end
        check_val({tag, " strobes"}, 32'(n_strb), 32'd1);
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " quotient"}, q_c, exp_q);
        check_val({tag, " remainder"}, r_c, exp_r);
        check_val({tag, " exception"}, {31'h0, e_c}, {31'h0, exp_exc});
        check_val({tag, " hold"}, quotient, exp_q);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_exc,
                           input int exp_lat);
        pulse(a, b);
        wait_result(tag, exp_q, exp_r, exp_exc, exp_lat);
    endtask

    initial begin
        int n_strb;
        int ra;
        int rb;
        err_cnt  = 0;
        chk_cnt  = 0;
        reset_n  = 1'b0;
        ctrl_DIV = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;

        repeat (3) @(negedge clock);
        check_val("reset quotient", quotient, 32'h0);
        check_val("reset rdy", {31'h0, data_resultRDY}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("idle busy", {31'h0, busy}, 32'h0);

        run_div("7/2",     32'd7,         32'd2,         32'd3,         32'd1,         1'b0, 33);
        run_div("-7/2",    32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33);
        run_div("7/-2",    32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 33);
        run_div("-7/-2",   32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 33);
        run_div("min/-1",  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         1'b0, 33);
        run_div("1234/0",  32'd1234,      32'h0,         32'h0,         32'h0,         1'b1, 1);
        run_div("0/5",     32'h0,         32'd5,         32'h0,         32'h0,         1'b0, 33);
        run_div("min/1",   32'h80000000,  32'd1,         32'h80000000,  32'h0,         1'b0, 33);
        run_div("max/max", 32'h7FFFFFFF,  32'h7FFFFFFF,  32'd1,         32'h0,         1'b0, 33);
        run_div("5/7",     32'd5,         32'd7,         32'h0,         32'd5,         1'b0, 33);
        run_div("-1/min",  32'hFFFFFFFF,  32'h80000000,  32'h0,         32'hFFFFFFFF,  1'b0, 33);

        // Restart mid-run: only the second operation may strobe.
        pulse(32'd100, 32'd7);
        n_strb = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) n_strb++;
        end
        check_val("abort early strobe", 32'(n_strb), 32'd0);
        run_div("restart 50/5", 32'd50, 32'd5, 32'd10, 32'h0, 1'b0, 33);

        // Start coinciding with DONE: old result still strobes, new op follows.
        pulse(32'd7, 32'd2);
        repeat (32) @(negedge clock);
        ctrl_DIV = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd3;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check_val("coincide rdy", {31'h0, data_resultRDY}, 32'h1);
        check_val("coincide quotient", quotient, 32'd3);
        wait_result("coincide 20/3", 32'd6, 32'd2, 1'b0, 33);

        // Asynchronous reset mid-run clears everything and suppresses the strobe.
        pulse(32'd100, 32'd7);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("mid reset quotient", quotient, 32'h0);
        check_val("mid reset remainder", remainder, 32'h0);
        check_val("mid reset busy", {31'h0, busy}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n_strb = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) n_strb++;
        end
        check_val("post reset strobes", 32'(n_strb), 32'd0);
        run_div("after reset 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        // Randomised pairs against the language's truncating division.
        for (int i = 0; i < 100; i++) begin
            ra = int'($urandom);
            if (i % 2 == 1) rb = int'($urandom_range(0, 40)) - 20;
            else            rb = int'($urandom) >>> (i % 31);
            if (rb == 0) rb = 3;
            if (ra == 32'sh80000000 && rb == -1) rb = 5;
            run_div("random", 32'(ra), 32'(rb), 32'(ra / rb), 32'(ra % rb), 1'b0, 33);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
